// File: rtl/pps_pkg.sv
// Shared types and constants for the GPS PPS conditioner.
package pps_pkg;

    // Qualification state of the incoming PPS stream.
    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2,
        HOLDOVER = 2'd3
    } pps_state_t;

    // Flip-flop stages used to bring the asynchronous PPS into the CLK domain.
    localparam int PPS_SYNC_STAGES = 2;

endpackage : pps_pkg

// File: rtl/pps_sync_edge.sv
// Synchroniser for the raw PPS input plus a registered rising-edge strobe.
// The strobe is high for one cycle, two cycles after the first clock that
// samples the input high.
module pps_sync_edge
    import pps_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [PPS_SYNC_STAGES-1:0] sync_q;
    logic                       prev_q;

    // Shift the input through the synchroniser and flag a 0->1 transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the value from before this edge.
            sync_q <= {sync_q[PPS_SYNC_STAGES-2:0], din};
            prev_q <= sync_q[PPS_SYNC_STAGES-1];
            rise   <= sync_q[PPS_SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule : pps_sync_edge

// File: rtl/gps_pps_conditioner.sv
// Qualifies raw GPS PPS: measures its period, tracks lock, and generates
// synthetic holdover pulses so downstream timing never stalls.
module gps_pps_conditioner #(
    parameter int  CLK_FREQ_HZ  = 32768000,
    parameter int  TOL_CYCLES   = 1000,
    parameter int  LOCK_COUNT   = 3,
    parameter int  HOLDOVER_MAX = 10,
    localparam int CW           = $clog2(CLK_FREQ_HZ + TOL_CYCLES + 1) + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          GPS_PPS,
    input  logic          ERR_CLR,
    output logic          PPS_OUT,
    output logic          PPS_VALID,
    output logic          HOLDOVER,
    output logic          PPS_ERR,
    output logic [CW-1:0] PERIOD_LAST
);
    // The HOLDOVER port shadows the enum literal, so state literals are scoped.
    import pps_pkg::pps_state_t;

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int HW = $clog2(HOLDOVER_MAX + 1);

    localparam logic [CW-1:0] EARLY_LIM  = CW'(CLK_FREQ_HZ - TOL_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_AT = CW'(CLK_FREQ_HZ + TOL_CYCLES);
    // A synthetic pulse stands in for a reference TOL_CYCLES+1 cycles in the past.
    localparam logic [CW-1:0] HO_RELOAD  = CW'(TOL_CYCLES + 1);
    localparam logic [GW-1:0] LOCK_TGT   = GW'(LOCK_COUNT);
    localparam logic [HW-1:0] HO_LIMIT   = HW'(HOLDOVER_MAX);

    pps_state_t    state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt, cnt_inc, period_nxt;
    logic [GW-1:0] good_q, good_nxt, good_inc;
    logic [HW-1:0] ho_q, ho_nxt, ho_inc;
    logic          pps_rise, is_early, is_good, timeout;
    logic          pulse_nxt, err_set;

    pps_sync_edge u_sync (
        .clk  (CLK),
        .rst  (RST),
        .din  (GPS_PPS),
        .rise (pps_rise)
    );

    // Classify the current edge against the period window.
    always_comb begin
        cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
        good_inc = good_q + GW'(1);
        ho_inc   = ho_q + HW'(1);
        is_early = pps_rise && (cnt_q < EARLY_LIM);
        is_good  = pps_rise && (cnt_q >= EARLY_LIM) && (cnt_q <= TIMEOUT_AT);
        timeout  = !pps_rise && (cnt_q == TIMEOUT_AT);
    end

    // Next-state, counter and pulse decisions.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt  = state_q;
        cnt_nxt    = cnt_inc;
        good_nxt   = good_q;
        ho_nxt     = ho_q;
        period_nxt = PERIOD_LAST;
        pulse_nxt  = 1'b0;
        err_set    = 1'b0;
        unique case (state_q)
            pps_pkg::SEARCH: begin
                if (pps_rise) begin
                    state_nxt = pps_pkg::LOCKING;
                    cnt_nxt   = '0;
                    good_nxt  = '0;
                    pulse_nxt = 1'b1;
                end
            end
            pps_pkg::LOCKING: begin
                if (is_good) begin
                    cnt_nxt    = '0;
                    pulse_nxt  = 1'b1;
                    period_nxt = cnt_q + CW'(1);
                    good_nxt   = good_inc;
                    if (good_inc == LOCK_TGT) begin
                        state_nxt = pps_pkg::LOCKED;
                        good_nxt  = '0;
                    end
                end else if (is_early) begin
                    cnt_nxt   = '0;
                    good_nxt  = '0;
                    pulse_nxt = 1'b1;
                    err_set   = 1'b1;
                end else if (timeout) begin
                    state_nxt = pps_pkg::SEARCH;
                end
            end
            pps_pkg::LOCKED: begin
                if (is_good) begin
                    cnt_nxt    = '0;
                    pulse_nxt  = 1'b1;
                    period_nxt = cnt_q + CW'(1);
                end else if (is_early) begin
                    err_set = 1'b1;
                end else if (timeout) begin
                    state_nxt = pps_pkg::HOLDOVER;
                    cnt_nxt   = HO_RELOAD;
                    ho_nxt    = HW'(1);
                    pulse_nxt = 1'b1;
                end
            end
            pps_pkg::HOLDOVER: begin
                if (is_good) begin
                    state_nxt  = pps_pkg::LOCKED;
                    cnt_nxt    = '0;
                    ho_nxt     = '0;
                    pulse_nxt  = 1'b1;
                    period_nxt = cnt_q + CW'(1);
                end else if (is_early) begin
                    err_set = 1'b1;
                end else if (timeout) begin
                    cnt_nxt   = HO_RELOAD;
                    pulse_nxt = 1'b1;
                    ho_nxt    = ho_inc;
                    if (ho_inc == HO_LIMIT) begin
                        state_nxt = pps_pkg::SEARCH;
                        ho_nxt    = '0;
                    end
                end
            end
        endcase
    end

    // State, counters and outputs advance together so status lines up with PPS_OUT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: only a handful of flops here, so every one is reset; there is no memory array to leave unreset.
            state_q     <= pps_pkg::SEARCH;
            cnt_q       <= '0;
            good_q      <= '0;
            ho_q        <= '0;
            PPS_OUT     <= 1'b0;
            PPS_VALID   <= 1'b0;
            HOLDOVER    <= 1'b0;
            PPS_ERR     <= 1'b0;
            PERIOD_LAST <= '0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            good_q      <= good_nxt;
            ho_q        <= ho_nxt;
            PPS_OUT     <= pulse_nxt;
            PPS_VALID   <= (state_nxt == pps_pkg::LOCKED) || (state_nxt == pps_pkg::HOLDOVER);
            HOLDOVER    <= (state_nxt == pps_pkg::HOLDOVER);
            PERIOD_LAST <= period_nxt;
            if (err_set) begin
                PPS_ERR <= 1'b1;
            end else if (ERR_CLR) begin
                PPS_ERR <= 1'b0;
            end
        end
    end

endmodule : gps_pps_conditioner
